// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that time-shares one external combinational ALU.
// Each grant runs IDLE -> EXEC -> DONE: operands are latched, the result is captured, then acked.
module alu_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] alu_A,
    output logic [W-1:0] alu_B,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_out,
    input  logic         alu_z,
    output logic [W-1:0] result,
    output logic         z_out,
    output logic         done,
    output logic         done_id,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         prio_q, prio_d;
    logic         owner_q, owner_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]   op_q, op_d;
    logic         z_q, z_d;
    logic         did_q, did_d;
    logic         win;

    // A lone requester wins outright; on a tie the priority pointer decides.
    assign win = (req0 && req1) ? prio_q : req1;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        z_d     = z_q;
        did_d   = did_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = win;
                    a_d     = win ? a1  : a0;
                    b_d     = win ? b1  : b0;
                    op_d    = win ? op1 : op0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_out;
                z_d     = alu_z;
                did_d   = owner_q;
                prio_d  = ~owner_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
            z_q     <= 1'b0;
            did_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            z_q     <= z_d;
            did_q   <= did_d;
        end
    end

    assign alu_A   = a_q;
    assign alu_B   = b_q;
    assign alu_op  = op_q;
    assign result  = res_q;
    assign z_out   = z_q;
    assign done_id = did_q;
    assign done    = (state_q == DONE);
    assign ack0    = done && !owner_q;
    assign ack1    = done &&  owner_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised self-checking bench for alu_arbiter with an external ALU model
// and a transaction-level reference for results, latency and round-robin order.
module tb_alu_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1;
    logic [W-1:0] alu_A, alu_B;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         alu_z;
    logic [W-1:0] result;
    logic         z_out, done, done_id, busy;

    int checks = 0;
    int errs   = 0;
    bit m_prio = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    // External ALU, wired as it would be in the system
    assign alu_out = ref_alu(alu_op, alu_A, alu_B);
    assign alu_z   = (alu_out == '0);

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z),
        .result(result), .z_out(z_out),
        .done(done), .done_id(done_id), .busy(busy)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        m_prio = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 12);
    endtask

    // One solo request; returns at the negedge of the following IDLE cycle.
    task automatic do_op(input bit id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        logic [W-1:0] exp;
        exp = ref_alu(op, a, b);
        @(negedge clk);
        if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        wait_done(cyc);
        checks++; if (cyc !== 2) begin errs++; $display("FAIL op_latency: got %0d cycles, expected 2", cyc); end
        checks++; if (result !== exp) begin errs++; $display("FAIL op_result: id %0d op %0d a %h b %h got %h expected %h", id, op, a, b, result, exp); end
        checks++; if (z_out !== (exp == '0)) begin errs++; $display("FAIL op_zflag: got %b expected %b", z_out, exp == '0); end
        checks++; if ({ack1, ack0} !== (id ? 2'b10 : 2'b01)) begin errs++; $display("FAIL op_ack: got %b expected id %0d", {ack1, ack0}, id); end
        checks++; if (done_id !== id) begin errs++; $display("FAIL op_done_id: got %b expected %b", done_id, id); end
        m_prio = ~id;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL op_idle: busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({alu_A, alu_B, alu_op} !== '0) begin errs++; $display("FAIL reset_alu_regs: got %h %h %b expected 0", alu_A, alu_B, alu_op); end
        checks++; if ({result, z_out} !== '0) begin errs++; $display("FAIL reset_result: got %h %b expected 0", result, z_out); end
        checks++; if ({done, done_id, ack0, ack1, busy} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b expected 00000", {done, done_id, ack0, ack1, busy}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle: busy %b expected 0", busy); end
    endtask

    task automatic test_directed();
        do_op(0, 2'b00, 16'd3, 16'd4);
        do_op(1, 2'b01, 16'h1234, 16'h1234);
        do_op(1, 2'b00, 16'hFFFF, 16'h0001);
        do_op(0, 2'b10, 16'hF0F0, 16'h3C3C);
        do_op(1, 2'b11, 16'hAAAA, 16'h00FF);
    endtask

    task automatic test_random_solo();
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            logic [1:0] op;
            a = W'($urandom); b = W'($urandom); op = 2'($urandom);
            if ($urandom_range(3) == 0) begin b = a; op = 2'b01; end
            do_op(1'($urandom), op, a, b);
        end
    endtask

    // Both request together; the model's pointer picks the first winner.
    task automatic test_random_tie();
        for (int i = 0; i < 8; i++) begin
            int cyc;
            bit w;
            logic [W-1:0] e0, e1;
            @(negedge clk);
            op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
            op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            e0 = ref_alu(op0, a0, b0); e1 = ref_alu(op1, a1, b1);
            req0 = 1'b1; req1 = 1'b1;
            w = m_prio;
            wait_done(cyc);
            checks++; if (cyc !== 2 || done_id !== w) begin errs++; $display("FAIL tie_first: cyc %0d id %b expected 2 %b", cyc, done_id, w); end
            checks++; if (result !== (w ? e1 : e0)) begin errs++; $display("FAIL tie_first_result: got %h expected %h", result, w ? e1 : e0); end
            if (w) req1 = 1'b0; else req0 = 1'b0;
            m_prio = ~w;
            wait_done(cyc);
            checks++; if (cyc !== 3 || done_id !== ~w) begin errs++; $display("FAIL tie_second: cyc %0d id %b expected 3 %b", cyc, done_id, ~w); end
            checks++; if (result !== (w ? e0 : e1)) begin errs++; $display("FAIL tie_second_result: got %h expected %h", result, w ? e0 : e1); end
            req0 = 1'b0; req1 = 1'b0;
            m_prio = w;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int ids[$];
        logic [W-1:0] res[$];
        bit drop0 = 0, drop1 = 0;
        apply_reset();
        op0 = 2'b00; a0 = 16'd1; b0 = 16'd1;
        op1 = 2'b00; a1 = 16'd2; b1 = 16'd2;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++; if (ack0 && ack1) begin errs++; $display("FAIL rr_overlap: ack0 %b ack1 %b expected not both", ack0, ack1); end
            if (ack0) begin ids.push_back(0); res.push_back(result); req0 = 1'b0; drop0 = 1; end
            else if (drop0) begin req0 = 1'b1; drop0 = 0; end
            if (ack1) begin ids.push_back(1); res.push_back(result); req1 = 1'b0; drop1 = 1; end
            else if (drop1) begin req1 = 1'b1; drop1 = 0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (ids.size() < 4) begin errs++; $display("FAIL rr_count: got %0d acks expected at least 4", ids.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                if (ids[k] !== (k % 2) || res[k] !== ((k % 2) ? 16'd4 : 16'd2)) begin
                    errs++; $display("FAIL rr_order: ack %0d id %0d result %h expected id %0d result %h", k, ids[k], res[k], k % 2, (k % 2) ? 4 : 2);
                end
            end
        end
        apply_reset();
    endtask

    task automatic test_operand_latch();
        int cyc;
        @(negedge clk);
        req0 = 1'b1; op0 = 2'b00; a0 = 16'd5; b0 = 16'd6;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || alu_A !== 16'd5) begin errs++; $display("FAIL latch_exec: busy %b alu_A %h expected 1 0005", busy, alu_A); end
        a0 = 16'h1000; b0 = 16'h0000;
        wait_done(cyc);
        checks++; if (cyc !== 1 || result !== 16'h000B) begin errs++; $display("FAIL latch_result: cyc %0d result %h expected 1 000b", cyc, result); end
        req0 = 1'b0;
        m_prio = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        req0 = 1'b1; op0 = 2'b00; a0 = 16'd9; b0 = 16'd9;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL midrst_exec: busy %b expected 1", busy); end
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        checks++; if ({busy, done, ack0, ack1} !== 4'b0 || result !== '0 || alu_A !== '0) begin
            errs++; $display("FAIL midrst_outputs: busy %b done %b ack %b%b result %h alu_A %h expected all 0", busy, done, ack1, ack0, result, alu_A);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ack0 !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL midrst_noack: ack0 %b done %b expected 0 0", ack0, done); end
        end
        rst_n = 1'b1; m_prio = 1'b0;
        do_op(1, 2'b00, 16'd7, 16'd8);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_solo();
        test_random_tie();
        test_round_robin();
        test_operand_latch();
        test_reset_mid_exec();
        test_random_tie();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single combinational 16-bit ALU between two requesters, such as the CPU datapath and a debug/DMA unit.
- It latches the winning requester's opcode and operands into registers that drive the ALU inputs.
- It captures the ALU result and zero flag one cycle later.
- It returns result, flag and a one-cycle acknowledge to the owner.
- It sits between the requesters and the ALU; the ALU itself is instantiated outside and wired to the alu_* ports.

## Interface
Parameters:
- W, 16, datapath width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; held high until its ack.
- op0 / op1  in  2  ALU opcode (00 add, 01 sub, 10 and, 11 not B).
- a0, b0 / a1, b1  in  W  operands; must be stable while req is high and unacked.
- ack0 / ack1  out  1  one-cycle pulse: request served, result/z_out valid.
- alu_A, alu_B  out  W  registered operands to the ALU val_A/val_B.
- alu_op  out  2  registered opcode to the ALU ALU_op.
- alu_out  in  W  ALU result.
- alu_z  in  1  ALU zero flag.
- result  out  W  captured result; holds until the next capture.
- z_out  out  1  captured zero flag; holds until the next capture.
- done  out  1  one-cycle pulse, equal to ack0 | ack1.
- done_id  out  1  owner of the current result (0/1); valid when done=1, holds afterwards.
- busy  out  1  high in EXEC and DONE.

## Operation
FSM states: IDLE, EXEC, DONE.

IDLE:
- If no req is high, stay in IDLE.
- If exactly one req is high, grant it.
- If both are high, grant the requester indicated by the priority pointer `prio`.
- On grant: load alu_A/alu_B/alu_op from the winner's a/b/op, record the owner, go to EXEC.

EXEC:
- ALU settles combinationally.
- At the clock edge, capture alu_out into result and alu_z into z_out.
- Set `prio` to the other requester (not the owner). Go to DONE.

DONE:
- done=1, ack[owner]=1, done_id=owner. Go to IDLE unconditionally.

Fixed rules:
- `prio` updates only when a request is served; `prio` reset value is 0 (requester 0 wins the first tie).
- Operands are latched at grant. Requester input changes after grant do not affect the result.
- The requester must drop req in the cycle after its ack. If req is still high, it is sampled in IDLE as a new request.
- Arithmetic is mod 2^W, performed by the ALU; no carry or overflow is reported.
- z_out comes directly from the ALU (result == 0). Op 11 ignores alu_A.
- alu_A/alu_B/alu_op hold their last value in IDLE. No new grant occurs until the FSM returns to IDLE.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, prio=0, owner=0.
- Reset values: alu_A=0, alu_B=0, alu_op=00, result=0, z_out=0, done=0, done_id=0, ack0=ack1=0, busy=0.
- Latency: req sampled high at edge k (end of an IDLE cycle) → EXEC during cycle k+1 → ack/done/result valid during cycle k+2.
- Throughput: one operation per 3 cycles. Two continuously asserted requesters each get one op per 6 cycles, alternating.
- Reset mid-operation (EXEC or DONE): immediate return to IDLE with all outputs at reset values. No ack is issued and the interrupted operation is dropped. The requester re-requests after reset release.
- A request arriving while busy=1 is not lost; it is sampled in the next IDLE cycle.

## Test plan
- Single request: req0=1, op0=00, a0=3, b0=4 → done/ack0 two cycles after the sampling edge; result=0x0007, z_out=0, done_id=0. Drop req0 → FSM stays IDLE, busy=0.
- Zero flag and wrap: req1 sub with a1=b1=0x1234 → result=0, z_out=1, ack1. Then req1 add 0xFFFF+0x0001 → result=0x0000, z_out=1.
- Op coverage: and 0xF0F0 & 0x3C3C → 0x3030. Not with b=0x00FF (a=0xAAAA) → 0xFF00, z_out=0.
- Round-robin: after reset, hold req0 and req1 high (ops add 1+1, add 2+2), each dropping req the cycle after its ack and re-raising it one cycle later → ack order 0,1,0,1; results alternate 2,4; no ack0 and ack1 overlap.
- Operand latching: grant req0 (a0=5, b0=6, add), change a0 to 0x1000 during EXEC → result=0x000B.
- Reset mid-EXEC: assert rst_n=0 during EXEC → no ack, result=0, busy=0. After release, req1 add 7+8 → result=0x000F, served normally with prio=0 semantics.
